// File: rtl/sdrc_req_fifo.sv
// rtl/sdrc_req_fifo.sv - application request queue ahead of the SDRAM request generator
//
// Buffers up to DEPTH application transfer requests and tags each one with a
// rolling ID. The oldest request is presented to the request generator with
// the req/req_ack handshake.
//
// Ports:
//   clk, reset_n          clock; asynchronous active-low reset
//   app_req*              application request (valid, addr, len, wr_n, wrap)
//   app_req_ack/_id       combinational accept and the ID given to the request
//   req, req_*            head entry presented to the request generator
//   req_ack               request generator consumed the head entry
//   r2x_idle              request generator idle
//   len_err               one-cycle pulse after a zero-length request is dropped
//   fifo_level            occupied entries
//   sdrc_idle             queue empty and request generator idle
`ifndef SDR_REQ_ID_W
`define SDR_REQ_ID_W 4
`endif

module sdrc_req_fifo #(
  parameter int APP_AW = 30,
  parameter int APP_RW = 9,
  parameter int ID_W   = `SDR_REQ_ID_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     app_req,
  input  logic [APP_AW-1:0]        app_req_addr,
  input  logic [APP_RW-1:0]        app_req_len,
  input  logic                     app_req_wr_n,
  input  logic                     app_req_wrap,
  output logic                     app_req_ack,
  output logic [ID_W-1:0]          app_req_id,
  output logic                     req,
  output logic [ID_W-1:0]          req_id,
  output logic [APP_AW-1:0]        req_addr,
  output logic [APP_RW-1:0]        req_len,
  output logic                     req_wr_n,
  output logic                     req_wrap,
  input  logic                     req_ack,
  input  logic                     r2x_idle,
  output logic                     len_err,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     sdrc_idle
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [ID_W-1:0]   mem_id   [DEPTH];
  logic [APP_AW-1:0] mem_addr [DEPTH];
  logic [APP_RW-1:0] mem_len  [DEPTH];
  logic              mem_wr_n [DEPTH];
  logic              mem_wrap [DEPTH];

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic [ID_W-1:0] id_cnt;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic zero_len;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign zero_len = (app_req_len == '0);

  // Accept depends only on the registered occupancy, so a pop in the same
  // cycle does not free a slot for a request arriving while full.
  assign app_req_ack = app_req & ~full;
  assign app_req_id  = id_cnt;
  // Zero-length requests are acknowledged but never enter the queue.
  assign push        = app_req_ack & ~zero_len;
  assign pop         = req_ack & ~empty;

  assign req        = ~empty;
  assign req_id     = mem_id[rd_ptr];
  assign req_addr   = mem_addr[rd_ptr];
  assign req_len    = mem_len[rd_ptr];
  assign req_wr_n   = mem_wr_n[rd_ptr];
  assign req_wrap   = mem_wrap[rd_ptr];
  assign fifo_level = count;
  assign sdrc_idle  = empty & r2x_idle;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      id_cnt  <= '0;
      len_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        id_cnt <= id_cnt + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      len_err <= app_req_ack & zero_len;
    end
  end

  // Entry storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wr_ptr]   <= id_cnt;
      mem_addr[wr_ptr] <= app_req_addr;
      mem_len[wr_ptr]  <= app_req_len;
      mem_wr_n[wr_ptr] <= app_req_wr_n;
      mem_wrap[wr_ptr] <= app_req_wrap;
    end
  end

endmodule

// File: tb/tb_sdrc_req_fifo.sv
// tb/tb_sdrc_req_fifo.sv - scoreboard bench for sdrc_req_fifo
module tb_sdrc_req_fifo;

  localparam int AW = 30;
  localparam int RW = 9;
  localparam int IW = 4;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          app_req = 1'b0;
  logic [AW-1:0] app_req_addr = '0;
  logic [RW-1:0] app_req_len = '0;
  logic          app_req_wr_n = 1'b0;
  logic          app_req_wrap = 1'b0;
  logic          app_req_ack;
  logic [IW-1:0] app_req_id;
  logic          req;
  logic [IW-1:0] req_id;
  logic [AW-1:0] req_addr;
  logic [RW-1:0] req_len;
  logic          req_wr_n;
  logic          req_wrap;
  logic          req_ack = 1'b0;
  logic          r2x_idle = 1'b1;
  logic          len_err;
  logic [2:0]    fifo_level;
  logic          sdrc_idle;

  sdrc_req_fifo #(.APP_AW(AW), .APP_RW(RW), .ID_W(IW), .DEPTH(DP)) dut (
    .clk(clk), .reset_n(reset_n),
    .app_req(app_req), .app_req_addr(app_req_addr), .app_req_len(app_req_len),
    .app_req_wr_n(app_req_wr_n), .app_req_wrap(app_req_wrap),
    .app_req_ack(app_req_ack), .app_req_id(app_req_id),
    .req(req), .req_id(req_id), .req_addr(req_addr), .req_len(req_len),
    .req_wr_n(req_wr_n), .req_wrap(req_wrap), .req_ack(req_ack),
    .r2x_idle(r2x_idle), .len_err(len_err), .fifo_level(fifo_level),
    .sdrc_idle(sdrc_idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int addr;
    int len;
    int wr_n;
    int wrap;
  } entry_t;

  entry_t exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int occ = 0;
  int model_id = 0;
  int exp_len_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every consumed head entry must be the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && req && req_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_head", 1, 0);
        end else begin
          entry_t e;
          e = exp_q.pop_front();
          chk("req_id", req_id, e.id);
          chk("req_addr", req_addr, e.addr);
          chk("req_len", req_len, e.len);
          chk("req_wr_n", req_wr_n, e.wr_n);
          chk("req_wrap", req_wrap, e.wrap);
        end
      end
    end
  end

  // Drive one cycle of inputs, check sideband outputs against the model,
  // then advance the model across the coming clock edge.
  task automatic step(input int r, input int a, input int l, input int w,
                      input int wp, input int ak, input int idle);
    int exp_ack;
    int psh;
    int pp;
    app_req = r[0];
    app_req_addr = AW'(a);
    app_req_len = RW'(l);
    app_req_wr_n = w[0];
    app_req_wrap = wp[0];
    req_ack = ak[0];
    r2x_idle = idle[0];
    @(negedge clk);
    #1;
    exp_ack = (r != 0 && occ < DP) ? 1 : 0;
    chk("app_req_ack", app_req_ack, exp_ack);
    chk("app_req_id", app_req_id, model_id);
    chk("req_valid", req, (occ != 0) ? 1 : 0);
    chk("fifo_level", fifo_level, occ);
    chk("sdrc_idle", sdrc_idle, (occ == 0 && idle != 0) ? 1 : 0);
    chk("len_err", len_err, exp_len_err);
    psh = (exp_ack != 0 && l != 0) ? 1 : 0;
    pp = (ak != 0 && occ > 0) ? 1 : 0;
    if (psh != 0) begin
      exp_q.push_back('{model_id, a, l, w, wp});
      model_id = (model_id + 1) % (1 << IW);
    end
    occ = occ + psh - pp;
    exp_len_err = (exp_ack != 0 && l == 0) ? 1 : 0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1, 1);
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", req, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_len_err", len_err, 0);
    reset_n = 1'b1;

    // Single write, then consume
    step(1, 'h100, 8, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Fill beyond depth, then one pop frees a slot
    for (int i = 0; i < 5; i++) step(1, 'h200 + i, i + 1, 1, i & 1, 0, 1);
    step(1, 'h204, 5, 1, 0, 1, 1);
    step(1, 'h204, 5, 1, 0, 0, 1);
    drain(6);

    // Streaming with continuous consumption, IDs wrap
    for (int i = 0; i < 40; i++) step(1, 'h1000 + i * 4, 16, i & 1, 0, 1, 0);
    drain(3);

    // Zero-length request between two len-4 requests
    step(1, 'h300, 4, 0, 0, 0, 1);
    step(1, 'h304, 0, 0, 0, 0, 1);
    step(1, 'h308, 4, 1, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    drain(3);

    // Asynchronous reset with entries queued and len_err pending
    step(1, 'h400, 2, 0, 0, 0, 1);
    step(1, 'h404, 2, 0, 0, 0, 1);
    step(1, 'h408, 2, 0, 0, 0, 1);
    step(1, 'h40c, 0, 0, 0, 0, 1);
    app_req = 1'b0;
    req_ack = 1'b0;
    #2;
    chk("pre_rst_len_err", len_err, 1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_req", req, 0);
    chk("async_rst_level", fifo_level, 0);
    chk("async_rst_len_err", len_err, 0);
    exp_q.delete();
    occ = 0;
    model_id = 0;
    exp_len_err = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1, 'h500, 3, 1, 0, 0, 1);
    drain(2);

    // Spurious consume while empty
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    step(1, 'h600, 7, 0, 1, 0, 1);
    drain(2);

    // Randomized traffic in phases of differing backpressure
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 400; i++) begin
        int r;
        int l;
        int ak;
        r = ($urandom_range(0, 3) != 0) ? 1 : 0;
        l = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 511));
        ak = (int'($urandom_range(0, 3)) <= ph) ? 1 : 0;
        step(r, int'($urandom & 32'h3fff_ffff), l, int'($urandom_range(0, 1)),
             int'($urandom_range(0, 1)), ak, int'($urandom_range(0, 1)));
      end
    end
    drain(8);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sdrc_req_fifo.md
# sdrc_req_fifo

Application-side request queue for the SDRAM controller, sitting directly upstream of the request generator. Accepts transfer requests from the application port, tags each with a rolling request ID, buffers up to DEPTH of them, and presents the oldest to the request generator using its req/req_ack handshake. Decouples application issue from bank-controller backpressure and provides an idle indication for the controller top level.

## Interface
- APP_AW, 30, application address width
- APP_RW, 9, request length width (32-bit words)
- ID_W, `SDR_REQ_ID_W, request ID width
- DEPTH, 4, queue entries; power of two, ≥2
- clk  input  1  clock, all state on rising edge
- reset_n  input  1  reset; asynchronous, active-low
- app_req  input  1  application request valid
- app_req_addr  input  APP_AW  request address
- app_req_len  input  APP_RW  request length
- app_req_wr_n  input  1  0 write, 1 read
- app_req_wrap  input  1  wrap on page boundary
- app_req_ack  output  1  request accepted this cycle (combinational)
- app_req_id  output  ID_W  ID assigned to the request being acked (combinational)
- req  output  1  head entry valid toward request generator
- req_id, req_addr, req_len, req_wr_n, req_wrap  output  ID_W/APP_AW/APP_RW/1/1  head entry fields
- req_ack  input  1  request generator consumed head entry
- r2x_idle  input  1  request generator idle
- len_err  output  1  one-cycle pulse: zero-length request was acked and dropped
- fifo_level  output  log2(DEPTH)+1  occupied entries
- sdrc_idle  output  1  queue empty and r2x_idle high

## Operation
- Storage: DEPTH-entry circular buffer, fields {id, addr, len, wr_n, wrap}; write pointer, read pointer (log2(DEPTH) bits, wrap naturally), occupancy count (log2(DEPTH)+1 bits).
- full = (count == DEPTH); empty = (count == 0).
- app_req_ack = app_req & ~full. Pop-through when full is not supported: a simultaneous req_ack while full does not enable ack in the same cycle.
- push = app_req_ack & (app_req_len != 0). Writes entry at wr_ptr with id = id_cnt; wr_ptr += 1; id_cnt += 1 (mod 2^ID_W).
- Zero-length: app_req_ack still asserted; nothing enqueued; id_cnt unchanged; len_err = 1 in the following cycle.
- app_req_id = id_cnt (ID the entry receives if pushed).
- req = ~empty; req_* fields = buffer[rd_ptr]. When empty, field values are don't-care.
- pop = req_ack & req; rd_ptr += 1. req_ack while empty is ignored (no pointer or count change).
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Order preserved strictly FIFO; no reordering, no coalescing.
- sdrc_idle = empty & r2x_idle (combinational).

## Timing
- Reset (reset_n low, asynchronous): wr_ptr = rd_ptr = 0, count = 0, id_cnt = 0, len_err = 0; hence req = 0, fifo_level = 0, app_req_ack = 0 if ... only with app_req & ~full, i.e. ack follows app_req immediately after reset. Buffer contents are not reset.
- Reset mid-operation discards all queued entries; first post-reset request receives ID 0.
- Push-to-req latency: 1 cycle (entry pushed at edge N visible on req at N+1 when queue previously empty).
- Pop: head advances at the edge where req_ack is high; next entry (if any) presented the following cycle with no bubble.
- Sustained throughput: one push and one pop per cycle when not full.
- Full: app_req_ack held 0 until a pop lowers count; ack then reasserts the cycle after the pop.
- ID wrap: after 2^ID_W pushes id_cnt returns to 0.
- len_err: registered; high exactly one cycle after each zero-length ack.

## Test plan
- Reset then single write: app_req addr 0x100, len 8, wr_n 0 -> app_req_ack=1, app_req_id=0; next cycle req=1, req_addr=0x100, req_len=8, req_id=0; req_ack -> req=0, fifo_level=0, sdrc_idle=1 when r2x_idle=1.
- Fill: 5 back-to-back requests with req_ack=0, DEPTH=4 -> acks on first 4 (IDs 0..3), 5th held, fifo_level=4; one req_ack -> 5th acked next cycle with ID 4; drain order 0,1,2,3,4.
- Streaming: continuous app_req and req_ack every cycle for 40 requests -> one ack per cycle, fifo_level stays 1, IDs wrap 15->0 (ID_W=4), order intact.
- Zero length: app_req len 0 between two len-4 requests -> all three acked, len_err pulses one cycle, queued IDs 0 and 1 consecutive, fifo_level peaks at 2.
- Async reset with 3 entries queued mid-cycle -> req, fifo_level, len_err drop to 0 immediately; after release next request gets ID 0.
- Spurious req_ack while empty -> fifo_level stays 0, pointers unchanged, following push presents correct entry.
